// File: rtl/bram_load_arbiter_if.sv
// bram_load_arbiter_if: stream, compute-read and BRAM port A signals for the
// BRAM load arbiter. The arbiter connects through the slave modport. The
// master modport is the view seen by the surrounding system: the DMA,
// the compute engine and the BRAM.
interface bram_load_arbiter_if #(
    parameter int PTR_W = 9
);
    logic [31:0]    s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic           rd_req;
    logic [PTR_W-1:0] rd_addr;
    logic           rd_gnt;
    logic           rd_valid;
    logic [31:0]    rd_data;
    logic           load_done;
    logic [PTR_W:0] frame_words;
    logic           overflow;
    logic           clka;
    logic           rsta;
    logic           ena;
    logic [31:0]    addra;
    logic [31:0]    dina;
    logic [3:0]     wea;
    logic [31:0]    douta;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, rd_req, rd_addr, douta,
        output s_axis_tready, rd_gnt, rd_valid, rd_data, load_done, frame_words,
               overflow, clka, rsta, ena, addra, dina, wea
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, rd_req, rd_addr, douta,
        input  s_axis_tready, rd_gnt, rd_valid, rd_data, load_done, frame_words,
               overflow, clka, rsta, ena, addra, dina, wea
    );
endinterface

// File: rtl/bram_load_arbiter.sv
// bram_load_arbiter: owns BRAM port A and shares it between DMA stream writes
// (frame loads with overflow/drop handling) and compute-engine reads. Read
// data returns RD_LATENCY cycles after the grant, tagged by rd_valid.
// Build option: define BRAM_ARB_WR_PRIORITY_EN to replace round-robin with
// fixed write priority.
module bram_load_arbiter #(
    parameter int DEPTH_WORDS = 512,
    parameter int PTR_W       = 9,
    parameter int RD_LATENCY  = 2
) (
    input  logic               clk,
    input  logic               rst,
    bram_load_arbiter_if.slave bus
);

    typedef enum logic {ST_LOAD, ST_DROP} state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W:0]      frame_words_q;
    logic                overflow_q;
    logic                load_done_q;
    logic [RD_LATENCY-1:0] vld_q;

    logic                wr_gnt;
    logic                rd_gnt;
    logic                beat_wr;
    logic [PTR_W-1:0]    word_addr;

`ifndef BRAM_ARB_WR_PRIORITY_EN
    typedef enum logic {GNT_READ, GNT_WRITE} gnt_e;
    gnt_e                last_gnt_q;
`endif

    // One access per cycle; nothing is granted while reset is held.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (rst) begin
`ifdef BRAM_ARB_WR_PRIORITY_EN
            wr_gnt = bus.s_axis_tvalid;
            rd_gnt = bus.rd_req & ~bus.s_axis_tvalid;
`else
            if (bus.s_axis_tvalid && bus.rd_req) begin
                wr_gnt = (last_gnt_q == GNT_READ);
                rd_gnt = (last_gnt_q == GNT_WRITE);
            end else begin
                wr_gnt = bus.s_axis_tvalid;
                rd_gnt = bus.rd_req;
            end
`endif
        end
    end

    // A granted beat in drop mode is consumed but never reaches the BRAM.
    assign beat_wr   = wr_gnt && (state_q == ST_LOAD);
    assign word_addr = rd_gnt ? bus.rd_addr : wr_ptr_q;

    assign bus.s_axis_tready = wr_gnt;
    assign bus.rd_gnt        = rd_gnt;
    assign bus.ena           = beat_wr | rd_gnt;
    assign bus.wea           = beat_wr ? 4'hF : 4'h0;
    assign bus.addra         = {{(30-PTR_W){1'b0}}, word_addr, 2'b00};
    assign bus.dina          = bus.s_axis_tdata;
    assign bus.clka          = clk;
    assign bus.rsta          = ~rst;
    assign bus.rd_data       = bus.douta;
    assign bus.rd_valid      = vld_q[RD_LATENCY-1];
    assign bus.load_done     = load_done_q;
    assign bus.frame_words   = frame_words_q;
    assign bus.overflow      = overflow_q;

    // Frame loader: write pointer, drop mode on overflow, frame length and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            frame_words_q <= '0;
            overflow_q    <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (wr_gnt) begin
                if (state_q == ST_LOAD) begin
                    // First beat of a frame clears the previous frame's overflow.
                    if (wr_ptr_q == '0)
                        overflow_q <= 1'b0;
                    if (bus.s_axis_tlast) begin
                        wr_ptr_q      <= '0;
                        frame_words_q <= {1'b0, wr_ptr_q} + (PTR_W+1)'(1);
                        load_done_q   <= 1'b1;
                    end else if (wr_ptr_q == PTR_W'(DEPTH_WORDS-1)) begin
                        // Last word written; the rest of the frame drains unwritten.
                        state_q    <= ST_DROP;
                        overflow_q <= 1'b1;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                end else if (bus.s_axis_tlast) begin
                    state_q       <= ST_LOAD;
                    wr_ptr_q      <= '0;
                    frame_words_q <= (PTR_W+1)'(DEPTH_WORDS);
                    load_done_q   <= 1'b1;
                end
            end
        end
    end

`ifndef BRAM_ARB_WR_PRIORITY_EN
    // Round-robin memory: remembers the side of the most recent grant.
    always_ff @(posedge clk) begin
        if (!rst)
            last_gnt_q <= GNT_READ;
        else if (wr_gnt)
            last_gnt_q <= GNT_WRITE;
        else if (rd_gnt)
            last_gnt_q <= GNT_READ;
    end
`endif

    // Read-valid shift register aligned to the BRAM read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_gnt;
            for (int i = 1; i < RD_LATENCY; i++)
                vld_q[i] <= vld_q[i-1];
        end
    end

endmodule

// File: tb/tb_bram_load_arbiter.sv
// tb_bram_load_arbiter: directed and randomized frames/reads against a
// frame-level reference model (beat counts, memory image, due-time read queue).
module tb_bram_load_arbiter;
    localparam int DEPTH = 512;
    localparam int PW    = 9;
    localparam int L     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_load_arbiter_if #(.PTR_W(PW)) bus ();

    bram_load_arbiter #(
        .DEPTH_WORDS(DEPTH),
        .PTR_W(PW),
        .RD_LATENCY(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural BRAM: read-first, L-cycle read latency.
    logic [31:0] bram  [DEPTH];
    logic [31:0] dpipe [L];
    always @(posedge clk) begin
        if (bus.ena && bus.wea == 4'hF) bram[bus.addra[PW+1:2]] <= bus.dina;
        if (bus.ena && bus.wea == 4'h0) dpipe[0] <= bram[bus.addra[PW+1:2]];
        for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bus.douta = dpipe[L-1];

    // Reference model state
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nbeats = 0;     // beats accepted so far in current frame
    int          fw = 0;
    bit          ovf = 0;
    bit          ld_exp = 0;
    bit          last_w = 0;     // most recent grant went to the write side
    logic [31:0] mem   [DEPTH];
    bit          known [DEPTH];
    int          due_q [$];
    logic [31:0] dat_q [$];
    bit          kn_q  [$];
    logic        obs_rv, obs_ld, obs_ovf;
    logic [31:0] obs_rd;
    logic [PW:0] obs_fw;
    bit          wg, rg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant
    // outputs, then advance the model to the following cycle.
    task automatic step(input bit r, input bit tv, input bit tl, input logic [31:0] td,
                        input bit rq, input logic [PW-1:0] ra, output bit g_w, output bit g_r);
        bit exp_rv;
        bit wr;
        @(negedge clk);
        obs_rv = bus.rd_valid; obs_rd = bus.rd_data; obs_ld = bus.load_done;
        obs_fw = bus.frame_words; obs_ovf = bus.overflow;
        exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
        chk("rd_valid", obs_rv, exp_rv);
        if (exp_rv) begin
            if (kn_q[0]) chk("rd_data", obs_rd, dat_q[0]);
            void'(due_q.pop_front()); void'(dat_q.pop_front()); void'(kn_q.pop_front());
        end
        chk("load_done", obs_ld, ld_exp);
        chk("frame_words", obs_fw, fw);
        chk("overflow", obs_ovf, ovf);

        rst = r;
        bus.s_axis_tvalid = tv; bus.s_axis_tlast = tl; bus.s_axis_tdata = td;
        bus.rd_req = rq; bus.rd_addr = ra;
        #1;
        g_w = 0; g_r = 0;
        if (r) begin
`ifdef BRAM_ARB_WR_PRIORITY_EN
            g_w = tv; g_r = rq && !tv;
`else
            if (tv && rq) begin g_w = !last_w; g_r = last_w; end
            else begin g_w = tv; g_r = rq; end
`endif
        end
        wr = g_w && (nbeats < DEPTH);
        chk("tready", bus.s_axis_tready, g_w);
        chk("rd_gnt", bus.rd_gnt, g_r);
        chk("ena", bus.ena, wr || g_r);
        chk("wea", bus.wea, wr ? 4'hF : 4'h0);
        if (wr) begin
            chk("wr_addra", bus.addra, nbeats * 4);
            chk("dina", bus.dina, td);
        end
        if (g_r) chk("rd_addra", bus.addra, ra * 4);

        ld_exp = 0;
        if (!r) begin
            nbeats = 0; fw = 0; ovf = 0; last_w = 0;
            due_q.delete(); dat_q.delete(); kn_q.delete();
        end else begin
            if (g_w || g_r) last_w = g_w;
            if (g_r) begin
                due_q.push_back(cyc + L); dat_q.push_back(mem[ra]); kn_q.push_back(known[ra]);
            end
            if (g_w) begin
                if (nbeats == 0) ovf = 0;
                if (wr) begin mem[nbeats] = td; known[nbeats] = 1; end
                if (nbeats == DEPTH-1 && !tl) ovf = 1;
                nbeats++;
                if (tl) begin
                    fw = (nbeats < DEPTH) ? nbeats : DEPTH;
                    nbeats = 0;
                    ld_exp = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int k = 0; k < n; k++) step(1, 0, 0, 32'h0, 0, '0, a, b);
    endtask

    // AXIS source for one frame (data = base + beat index) with optional
    // concurrent reads; tvalid and rd_req are held until accepted.
    task automatic run_frame(input int n, input logic [31:0] base, input int pv, input int pr,
                             input bit rnd_addr, input logic [PW-1:0] fixed_addr);
        int i = 0;
        int guard = 0;
        int limit = 4 * n + 100;
        bit rq = 0, hold = 0, tv, a, b;
        logic [PW-1:0] ra = fixed_addr;
        while ((i < n || rq) && guard < limit) begin
            if (!rq && i < n && $urandom_range(99) < pr) begin
                rq = 1;
                ra = rnd_addr ? PW'($urandom_range(63)) : fixed_addr;
            end
            tv = (i < n) && (hold || $urandom_range(99) < pv);
            step(1, tv, i == n-1, base + i, rq, ra, a, b);
            hold = tv && !a;
            if (a) i++;
            if (b) rq = 0;
            guard++;
        end
        chk("frame_timeout", guard >= limit, 0);
    endtask

    initial begin
        bit pw;
        int i;
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.s_axis_tdata = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
        for (int k = 0; k < DEPTH; k++) begin mem[k] = '0; known[k] = 0; end

        // Reset held; outputs forced and state cleared.
        for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h55, 1, 1, wg, rg);
        idle(1);
        chk("rst_fw", obs_fw, 0);

        // 1: 8-beat frame, steady tvalid.
        run_frame(8, 32'h100, 100, 0, 0, '0);
        idle(1);
        chk("t1_ld", obs_ld, 1);
        chk("t1_fw", obs_fw, 8);
        idle(2);

        // 2: write and read contending every cycle.
        i = 0; pw = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, i < 5, i == 4, 32'h200 + i, 1, 3, wg, rg);
            chk("t2_one", wg + rg, 1);
            if (k > 0) chk("t2_alt", wg, !pw);
            pw = wg;
            if (wg) i++;
        end
        idle(L + 2);

        // 3: 514-beat frame overflows; next frame clears overflow.
        run_frame(514, 32'h1000, 100, 0, 0, '0);
        idle(1);
        chk("t3_ovf", obs_ovf, 1);
        chk("t3_fw", obs_fw, 512);
        run_frame(3, 32'h700, 100, 0, 0, '0);
        idle(1);
        chk("t3_ovf_clr", obs_ovf, 0);

        // 4: word 5 = DEADBEEF, read back after load_done.
        run_frame(8, 32'hDEADBEEF - 5, 100, 0, 0, '0);
        idle(1);
        chk("t4_ld", obs_ld, 1);
        step(1, 0, 0, 32'h0, 1, 5, wg, rg);
        chk("t4_gnt", rg, 1);
        idle(L);
        chk("t4_rv", obs_rv, 1);
        chk("t4_rd", obs_rd, 32'hDEADBEEF);

        // 5: reset after beat 3 of 6.
        for (int k = 0; k < 3; k++) step(1, 1, 0, 32'h500 + k, 0, '0, wg, rg);
        step(0, 1, 0, 32'h503, 0, '0, wg, rg);
        idle(2);
        chk("t5_no_ld", obs_ld, 0);
        run_frame(4, 32'h600, 100, 0, 0, '0);
        idle(2);

`ifdef BRAM_ARB_WR_PRIORITY_EN
        // 6: write priority starves reads while tvalid is high.
        begin
            int ng = 0;
            for (int k = 0; k < 10; k++) begin
                step(1, 1, k == 9, 32'h900 + k, 1, 2, wg, rg);
                if (rg) ng++;
            end
            chk("t6_no_rgnt", ng, 0);
            step(1, 0, 0, 32'h0, 1, 2, wg, rg);
            chk("t6_rgnt", rg, 1);
            idle(L + 2);
        end
`endif

        // Randomized frames with concurrent reads.
        for (int f = 0; f < 25; f++) begin
            run_frame($urandom_range(1, 40), $urandom(), 70, 40, 1, '0);
            idle($urandom_range(0, 3));
        end
        idle(L + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
